// File: rtl/asynchronous_fifo_controller.sv
// Pointer and flag controller for a clock-domain-crossing FIFO built around
// asynchronous_simple_dual_port_ram. Binary pointers address the RAM; their
// Gray-coded copies cross domains through SYNC_STAGES-deep flop synchronisers.
// Full, empty and the occupancy levels are derived from the local pointer and
// the delayed view of the remote pointer, so they are always conservative.
module asynchronous_fifo_controller #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     write_clock,
    input  logic                     write_resetn,
    input  logic                     read_clock,
    input  logic                     read_resetn,
    input  logic                     write_valid,
    output logic                     write_ready,
    output logic [ADDRESS_WIDTH:0]   write_level,
    input  logic                     read_enable,
    output logic                     read_empty,
    output logic                     read_data_valid,
    output logic [ADDRESS_WIDTH:0]   read_level,
    output logic                     memory_write_enable,
    output logic [ADDRESS_WIDTH-1:0] memory_write_address,
    output logic                     memory_read_enable,
    output logic [ADDRESS_WIDTH-1:0] memory_read_address
);

    localparam int unsigned AW = ADDRESS_WIDTH;

    // Full when the write Gray pointer equals the synced read Gray pointer with
    // its two top bits inverted; a mask keeps this valid down to AW == 1.
    localparam logic [AW:0] FULL_MASK = (AW + 1)'(3) << (AW - 1);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b = g;
        for (int unsigned i = 1; i <= AW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // ---------------- write domain ----------------
    logic [AW:0]                    write_pointer;
    logic [AW:0]                    write_pointer_next;
    logic [AW:0]                    write_gray;
    logic [SYNC_STAGES-1:0][AW:0]   rsync_chain;
    logic [AW:0]                    rsync;
    logic                           full;
    logic                           write_accept;

    // ---------------- read domain -----------------
    logic [AW:0]                    read_pointer;
    logic [AW:0]                    read_pointer_next;
    logic [AW:0]                    read_gray;
    logic [SYNC_STAGES-1:0][AW:0]   wsync_chain;
    logic [AW:0]                    wsync;
    logic                           read_pop;

    assign rsync = rsync_chain[SYNC_STAGES-1];
    assign wsync = wsync_chain[SYNC_STAGES-1];

    // Write-side flags, RAM write port and next pointer.
    always_comb begin
        full                 = (write_gray == (rsync ^ FULL_MASK));
        write_ready          = ~full;
        write_accept         = write_valid & ~full;
        memory_write_enable  = write_accept;
        memory_write_address = write_pointer[AW-1:0];
        write_pointer_next   = write_pointer + (AW + 1)'(write_accept);
        write_level          = write_pointer - gray2bin(rsync);
    end

    // Write pointer and its Gray copy advance together on each accepted word.
    always_ff @(posedge write_clock or negedge write_resetn) begin
        if (!write_resetn) begin
            write_pointer <= '0;
            write_gray    <= '0;
        end else begin
            write_pointer <= write_pointer_next;
            write_gray    <= bin2gray(write_pointer_next);
        end
    end

    // Bring the read Gray pointer into the write clock domain.
    always_ff @(posedge write_clock or negedge write_resetn) begin
        if (!write_resetn) begin
            rsync_chain <= '0;
        end else begin
            rsync_chain <= {rsync_chain[SYNC_STAGES-2:0], read_gray};
        end
    end

    // Read-side flags, RAM read port and next pointer.
    always_comb begin
        read_empty          = (read_gray == wsync);
        read_pop            = read_enable & ~read_empty;
        memory_read_enable  = read_pop;
        memory_read_address = read_pointer[AW-1:0];
        read_pointer_next   = read_pointer + (AW + 1)'(read_pop);
        read_level          = gray2bin(wsync) - read_pointer;
    end

    // Read pointer, its Gray copy and the one-cycle RAM read-latency qualifier.
    always_ff @(posedge read_clock or negedge read_resetn) begin
        if (!read_resetn) begin
            read_pointer    <= '0;
            read_gray       <= '0;
            read_data_valid <= 1'b0;
        end else begin
            read_pointer    <= read_pointer_next;
            read_gray       <= bin2gray(read_pointer_next);
            read_data_valid <= read_pop;
        end
    end

    // Bring the write Gray pointer into the read clock domain.
    always_ff @(posedge read_clock or negedge read_resetn) begin
        if (!read_resetn) begin
            wsync_chain <= '0;
        end else begin
            wsync_chain <= {wsync_chain[SYNC_STAGES-2:0], write_gray};
        end
    end

endmodule
